vend_dispenser: RTL

Output-side controller for the vending machine FSM. It consumes the machine's one-cycle `soda` strobe and 3-bit `change` code (change in nickels, 0–4) and drives the physical actuators. It runs the soda-release motor for a fixed time, then ejects the change as dimes first and then a nickel, with a request/acknowledge handshake to the coin mechanism. A one-entry request buffer absorbs back-to-back sales, and three sticky fault flags report anomalies.

---
 rtl/vend_pkg.sv | 50 +++++
 rtl/vend_req_buf.sv | 54 +++++
 rtl/vend_dispenser.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending-machine dispenser: state encoding,
// change-code constants and change-to-coin decode.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VEND   = 3'd1,
        DIME   = 3'd2,
        NICKEL = 3'd3,
        GAP    = 3'd4,
        DONE   = 3'd5
    } disp_state_t;

    localparam logic [2:0] CHG_0   = 3'd0;
    localparam logic [2:0] CHG_5   = 3'd1;
    localparam logic [2:0] CHG_10  = 3'd2;
    localparam logic [2:0] CHG_15  = 3'd3;
    localparam logic [2:0] CHG_20  = 3'd4;
    localparam logic [2:0] CHG_MAX = 3'd4;

    // Out-of-range codes are served as "no change" so the soda still vends.
    function automatic logic [2:0] chg_sanitize(input logic [2:0] code);
        if (code > CHG_MAX) begin
            return CHG_0;
        end else begin
            return code;
        end
    endfunction

    function automatic logic [1:0] chg_dimes(input logic [2:0] code);
        return code[2:1];
    endfunction

    function automatic logic chg_nickel(input logic [2:0] code);
        return code[0];
    endfunction

    // Dimes are always paid out before the nickel.
    function automatic disp_state_t next_coin_state(input logic [1:0] dimes,
                                                    input logic       nickel);
        if (dimes != 2'd0) begin
            return DIME;
        end else if (nickel) begin
            return NICKEL;
        end else begin
            return DONE;
        end
    endfunction

endpackage

// File: rtl/vend_req_buf.sv
// One-entry sale request buffer. A push is accepted when the slot is empty or
// is being popped in the same cycle; otherwise the push is reported as overrun.
module vend_req_buf
    import vend_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [2:0] data_i,
    output logic       valid_o,
    output logic       valid_nxt_o,
    output logic [2:0] data_o,
    output logic       overrun_o
);

    logic       valid_q;
    logic       valid_d;
    logic [2:0] data_q;
    logic [2:0] data_d;
    logic       accept_s;

    // Slot update: load wins over pop so a same-cycle pop+push keeps it full.
    always_comb begin
        accept_s  = push_i && (!valid_q || pop_i);
        overrun_o = push_i && valid_q && !pop_i;
        valid_d   = valid_q;
        data_d    = data_q;
        if (accept_s) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= CHG_0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o     = valid_q;
    assign valid_nxt_o = valid_d;
    assign data_o      = data_q;

endmodule

// File: rtl/vend_dispenser.sv
// Output-side dispenser controller: runs the soda motor, then pays change as
// dimes then a nickel through an ack handshake, with sticky fault reporting.
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int MOTOR_CYCLES = 8,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       soda,
    input  logic [2:0] change,
    input  logic       eject_ack,
    output logic       motor_on,
    output logic       eject_dime,
    output logic       eject_nickel,
    output logic       busy,
    output logic       vend_done,
    output logic       flt_overrun,
    output logic       flt_bad_code,
    output logic       flt_jam
);

    localparam int MW = $clog2(MOTOR_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [MW-1:0] MOT_LAST = MW'(MOTOR_CYCLES - 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(ACK_TIMEOUT);

    disp_state_t   state_q, state_d;
    logic [MW-1:0] mot_cnt_q, mot_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [TW-1:0] to_inc_s;
    logic [1:0]    dimes_q, dimes_d;
    logic          nick_q, nick_d;

    logic motor_on_q, motor_on_d;
    logic eject_dime_q, eject_dime_d;
    logic eject_nickel_q, eject_nickel_d;
    logic busy_q, busy_d;
    logic vend_done_q, vend_done_d;
    logic flt_overrun_q, flt_overrun_d;
    logic flt_bad_code_q, flt_bad_code_d;
    logic flt_jam_q, flt_jam_d;

    logic [2:0] chg_in_s;
    logic       bad_code_s;
    logic       jam_s;
    logic       buf_push_s;
    logic       buf_pop_s;
    logic       buf_valid_s;
    logic       buf_valid_nxt_s;
    logic [2:0] buf_data_s;
    logic       buf_overrun_s;

    // Buffer control: a sale arriving while not idle-and-empty is queued;
    // an idle controller always drains the buffer first.
    always_comb begin
        chg_in_s   = chg_sanitize(change);
        bad_code_s = soda && (change > CHG_MAX);
        buf_pop_s  = (state_q == IDLE) && buf_valid_s;
        buf_push_s = soda && !((state_q == IDLE) && !buf_valid_s);
    end

    vend_req_buf u_req_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (buf_push_s),
        .pop_i       (buf_pop_s),
        .data_i      (chg_in_s),
        .valid_o     (buf_valid_s),
        .valid_nxt_o (buf_valid_nxt_s),
        .data_o      (buf_data_s),
        .overrun_o   (buf_overrun_s)
    );

    // Sale sequencing: motor phase, coin handshakes with timeout, completion.
    always_comb begin
        state_d   = state_q;
        mot_cnt_d = mot_cnt_q;
        to_cnt_d  = to_cnt_q;
        dimes_d   = dimes_q;
        nick_d    = nick_q;
        jam_s     = 1'b0;
        to_inc_s  = to_cnt_q + TW'(1);
        case (state_q)
            IDLE: begin
                if (buf_valid_s) begin
                    state_d   = VEND;
                    mot_cnt_d = '0;
                    dimes_d   = chg_dimes(buf_data_s);
                    nick_d    = chg_nickel(buf_data_s);
                end else if (soda) begin
                    state_d   = VEND;
                    mot_cnt_d = '0;
                    dimes_d   = chg_dimes(chg_in_s);
                    nick_d    = chg_nickel(chg_in_s);
                end else begin
                    state_d = IDLE;
                end
            end
            VEND: begin
                if (mot_cnt_q == MOT_LAST) begin
                    state_d  = next_coin_state(dimes_q, nick_q);
                    to_cnt_d = '0;
                end else begin
                    mot_cnt_d = mot_cnt_q + MW'(1);
                end
            end
            DIME, NICKEL: begin
                if (eject_ack) begin
                    state_d = GAP;
                    if (state_q == DIME) begin
                        dimes_d = dimes_q - 2'd1;
                    end else begin
                        nick_d = 1'b0;
                    end
                end else if (to_inc_s == TO_LIMIT) begin
                    // Jammed mechanism: abandon the rest of the change.
                    jam_s   = 1'b1;
                    dimes_d = 2'd0;
                    nick_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    to_cnt_d = to_inc_s;
                end
            end
            GAP: begin
                state_d  = next_coin_state(dimes_q, nick_q);
                to_cnt_d = '0;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        motor_on_d     = (state_d == VEND);
        eject_dime_d   = (state_d == DIME);
        eject_nickel_d = (state_d == NICKEL);
        vend_done_d    = (state_d == DONE);
        busy_d         = (state_d != IDLE) || buf_valid_nxt_s;
        flt_overrun_d  = flt_overrun_q  || buf_overrun_s;
        flt_bad_code_d = flt_bad_code_q || bad_code_s;
        flt_jam_d      = flt_jam_q      || jam_s;
    end

    // State, counters, outputs and sticky faults.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mot_cnt_q      <= '0;
            to_cnt_q       <= '0;
            dimes_q        <= 2'd0;
            nick_q         <= 1'b0;
            motor_on_q     <= 1'b0;
            eject_dime_q   <= 1'b0;
            eject_nickel_q <= 1'b0;
            busy_q         <= 1'b0;
            vend_done_q    <= 1'b0;
            flt_overrun_q  <= 1'b0;
            flt_bad_code_q <= 1'b0;
            flt_jam_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            mot_cnt_q      <= mot_cnt_d;
            to_cnt_q       <= to_cnt_d;
            dimes_q        <= dimes_d;
            nick_q         <= nick_d;
            motor_on_q     <= motor_on_d;
            eject_dime_q   <= eject_dime_d;
            eject_nickel_q <= eject_nickel_d;
            busy_q         <= busy_d;
            vend_done_q    <= vend_done_d;
            flt_overrun_q  <= flt_overrun_d;
            flt_bad_code_q <= flt_bad_code_d;
            flt_jam_q      <= flt_jam_d;
        end
    end

    assign motor_on     = motor_on_q;
    assign eject_dime   = eject_dime_q;
    assign eject_nickel = eject_nickel_q;
    assign busy         = busy_q;
    assign vend_done    = vend_done_q;
    assign flt_overrun  = flt_overrun_q;
    assign flt_bad_code = flt_bad_code_q;
    assign flt_jam      = flt_jam_q;

endmodule
